axis_dwidth_64_32_tx: RTL

AXI4-Stream width downsizer from 64 to 32 bits. It takes 64-bit result words from a DUT output channel (tdata/tlast/valid/ready) and serialises each word into two 32-bit beats for the S2MM DMA port. It is the transmit-side counterpart of the 32-to-64 input packer, and sits between the DUT and the S2MM port in the reconfigurable partition wrapper. Beats carry tkeep; an all-zero upper-half keep suppresses the second beat, so packets with an odd 32-bit length are supported.

---
 rtl/axis_dwidth_64_32_tx.sv | 120 ++++++++++++
 1 files changed

// File: rtl/axis_dwidth_64_32_tx.sv
// AXI4-Stream 64->32 downsizer: each input word leaves as one or two 32-bit beats.
// Define AXIS_DW_HI_FIRST_EN to emit the upper half of each word first.
module axis_dwidth_64_32_tx #(
  parameter int OUT_W  = 32,
  parameter int KEEP_W = OUT_W / 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [2*OUT_W-1:0]    s_axis_tdata,
  input  logic [2*KEEP_W-1:0]   s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [OUT_W-1:0]      m_axis_tdata,
  output logic [KEEP_W-1:0]     m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_FIRST  = 2'd1;
  localparam logic [1:0] ST_SECOND = 2'd2;

  logic [1:0]            r_state;
  logic [2*OUT_W-1:0]    r_bufData;
  logic [2*KEEP_W-1:0]   r_bufKeep;
  logic                  r_bufLast;
  logic                  r_active;

  logic [OUT_W-1:0]      w_firstData;
  logic [OUT_W-1:0]      w_secondData;
  logic [KEEP_W-1:0]     w_firstKeep;
  logic [KEEP_W-1:0]     w_secondKeep;
  logic                  w_skip;
  logic                  w_accept;

`ifdef AXIS_DW_HI_FIRST_EN
  assign w_firstData  = r_bufData[2*OUT_W-1:OUT_W];
  assign w_firstKeep  = r_bufKeep[2*KEEP_W-1:KEEP_W];
  assign w_secondData = r_bufData[OUT_W-1:0];
  assign w_secondKeep = r_bufKeep[KEEP_W-1:0];
`else
  assign w_firstData  = r_bufData[OUT_W-1:0];
  assign w_firstKeep  = r_bufKeep[KEEP_W-1:0];
  assign w_secondData = r_bufData[2*OUT_W-1:OUT_W];
  assign w_secondKeep = r_bufKeep[2*KEEP_W-1:KEEP_W];
`endif

  // An empty second half means the word is finished after its first beat.
  assign w_skip = (w_secondKeep == '0);

  assign m_axis_tvalid = (r_state == ST_FIRST) || (r_state == ST_SECOND);

  // r_active holds ready low during reset and until the first edge after release.
  assign s_axis_tready = r_active &&
                         ((r_state == ST_EMPTY) ||
                          (m_axis_tready && (r_state == ST_SECOND)) ||
                          (m_axis_tready && (r_state == ST_FIRST) && w_skip));

  assign w_accept = s_axis_tvalid && s_axis_tready;

  always_comb begin
    m_axis_tdata = '0;
    m_axis_tkeep = '0;
    m_axis_tlast = 1'b0;
    case (r_state)
      ST_FIRST: begin
        m_axis_tdata = w_firstData;
        m_axis_tkeep = w_firstKeep;
        m_axis_tlast = r_bufLast && w_skip;
      end
      ST_SECOND: begin
        m_axis_tdata = w_secondData;
        m_axis_tkeep = w_secondKeep;
        m_axis_tlast = r_bufLast;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_active <= 1'b0;
    end else begin
      r_active <= 1'b1;
    end
  end

  // A capture always restarts at FIRST; it may coincide with the last beat leaving.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= ST_EMPTY;
      r_bufData <= '0;
      r_bufKeep <= '0;
      r_bufLast <= 1'b0;
    end else if (w_accept) begin
      r_state   <= ST_FIRST;
      r_bufData <= s_axis_tdata;
      r_bufKeep <= s_axis_tkeep;
      r_bufLast <= s_axis_tlast;
    end else begin
      case (r_state)
        ST_EMPTY: r_state <= ST_EMPTY;
        ST_FIRST: begin
          if (m_axis_tready) begin
            r_state <= w_skip ? ST_EMPTY : ST_SECOND;
          end
        end
        ST_SECOND: begin
          if (m_axis_tready) begin
            r_state <= ST_EMPTY;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

endmodule
